// File: rtl/inst_pair_queue.sv
// inst_pair_queue
// ----------------
// Circular queue of fetched instruction pairs sitting between fetch and
// decode. Each entry holds the PC of the first instruction and both
// instruction words in program order. The head entry is presented
// combinationally on pop_*. When the queue is empty, the head fields
// show the even-pipe nop, the odd-pipe lnop and a zero PC, so decode
// always sees harmless words.
//
// Ports
//   clock                       single clock; all state changes on its rising edge
//   reset                       asynchronous, active-low reset
//   push_valid / push_ready     fetch handshake; push_ready depends only on occupancy
//   push_pc                     PC of the first instruction of the pair
//   push_first / push_second    instruction words, in program order
//   pop_valid / pop_ready       decode handshake; pop_valid means the queue is non-empty
//   pop_pc / pop_first / pop_second   fields of the head entry
//   flush                       branch-taken flush; overrides push and pop
//   count                       current occupancy
//   flush_drops                 saturating count of entries discarded by flushes
module inst_pair_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [0:31] NOP_EVEN = 32'h40200000,
  parameter logic [0:31] LNOP_ODD = 32'h00200000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [0:31] push_pc,
  input  logic [0:31] push_first,
  input  logic [0:31] push_second,
  output logic        pop_valid,
  input  logic        pop_ready,
  output logic [0:31] pop_pc,
  output logic [0:31] pop_first,
  output logic [0:31] pop_second,
  input  logic        flush,
  output logic [0:4]  count,
  output logic [0:7]  flush_drops
);

  // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic [7:0]    drops_q, drops_d;
  logic [8:0]    drops_sum;

  logic [0:31] pc_mem     [DEPTH];
  logic [0:31] first_mem  [DEPTH];
  logic [0:31] second_mem [DEPTH];

  logic push_fire;
  logic pop_fire;

  assign push_ready = (count_q != 5'(DEPTH));
  assign pop_valid  = (count_q != 5'd0);
  assign push_fire  = push_valid & push_ready;
  assign pop_fire   = pop_valid & pop_ready;

  // One extra bit catches overflow of the drop counter so it can saturate.
  assign drops_sum = {1'b0, drops_q} + {4'b0000, count_q};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drops_d  = drops_q;
    if (flush) begin
      // Flush wins over any same-cycle push or pop; the whole contents
      // are discarded and tallied.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 5'd0;
      drops_d  = drops_sum[8] ? 8'hFF : drops_sum[7:0];
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + 5'd1;
        2'b01:   count_d = count_q - 5'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
      drops_q  <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drops_q  <= drops_d;
    end
  end

  // Entry storage has no reset; validity is tracked entirely by count.
  always_ff @(posedge clock) begin
    if (push_fire && !flush) begin
      pc_mem[wr_ptr_q]     <= push_pc;
      first_mem[wr_ptr_q]  <= push_first;
      second_mem[wr_ptr_q] <= push_second;
    end
  end

  // Head read is combinational from registered state only, so a pair
  // pushed into an empty queue shows up the cycle after its push.
  always_comb begin
    if (count_q == 5'd0) begin
      pop_pc     = 32'h0;
      pop_first  = NOP_EVEN;
      pop_second = LNOP_ODD;
    end else begin
      pop_pc     = pc_mem[rd_ptr_q];
      pop_first  = first_mem[rd_ptr_q];
      pop_second = second_mem[rd_ptr_q];
    end
  end

  assign count       = count_q;
  assign flush_drops = drops_q;

endmodule

// File: tb/tb_inst_pair_queue.sv
module tb_inst_pair_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        push_valid;
  logic        push_ready;
  logic [0:31] push_pc;
  logic [0:31] push_first;
  logic [0:31] push_second;
  logic        pop_valid;
  logic        pop_ready;
  logic [0:31] pop_pc;
  logic [0:31] pop_first;
  logic [0:31] pop_second;
  logic        flush;
  logic [0:4]  count;
  logic [0:7]  flush_drops;

  int n_vec = 0;
  int n_err = 0;

  inst_pair_queue #(
    .DEPTH(4),
    .NOP_EVEN(32'h40200000),
    .LNOP_ODD(32'h00200000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .push_valid(push_valid),
    .push_ready(push_ready),
    .push_pc(push_pc),
    .push_first(push_first),
    .push_second(push_second),
    .pop_valid(pop_valid),
    .pop_ready(pop_ready),
    .pop_pc(pop_pc),
    .pop_first(pop_first),
    .pop_second(pop_second),
    .flush(flush),
    .count(count),
    .flush_drops(flush_drops)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one clock edge; inputs and checks happen 1 time unit after it.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_push(input logic v, input logic [31:0] pc);
    push_valid  = v;
    push_pc     = pc;
    push_first  = 32'hA000_0000 | pc;
    push_second = 32'hB000_0000 | pc;
  endtask

  initial begin
    reset     = 1'b0;
    pop_ready = 1'b0;
    flush     = 1'b0;
    drive_push(1'b0, 32'h0);
    #12;

    // Values held during reset
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_pop_pc", pop_pc, 32'h0);
    chk("rst_pop_first", pop_first, 32'h40200000);
    chk("rst_pop_second", pop_second, 32'h00200000);
    chk("rst_drops", 32'(flush_drops), 32'd0);

    reset = 1'b1;
    #1;

    // Fill with decode stalled
    for (int i = 0; i < 4; i++) begin
      drive_push(1'b1, 32'(i * 8));
      cyc();
      chk($sformatf("fill_count_%0d", i), 32'(count), 32'(i + 1));
      if (i == 0) begin
        // Head visible one cycle after the push that filled the empty queue
        chk("fill_first_head", pop_pc, 32'h0);
        chk("fill_first_valid", 32'(pop_valid), 32'd1);
      end
    end
    chk("fill_push_ready", 32'(push_ready), 32'd0);
    chk("fill_head_pc", pop_pc, 32'h0);
    drive_push(1'b1, 32'h20);
    cyc();
    chk("fill_5th_count", 32'(count), 32'd4);
    chk("fill_5th_head", pop_pc, 32'h0);

    // Drain in order
    drive_push(1'b0, 32'h0);
    pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_pc_%0d", i), pop_pc, 32'(i * 8));
      chk($sformatf("drain_second_%0d", i), pop_second, 32'hB000_0000 | 32'(i * 8));
      cyc();
    end
    chk("drain_pop_valid", 32'(pop_valid), 32'd0);
    chk("drain_pop_first", pop_first, 32'h40200000);
    chk("drain_count", 32'(count), 32'd0);

    // Pop request against an empty queue does nothing
    cyc();
    chk("empty_pop_count", 32'(count), 32'd0);

    // Streaming at occupancy 2
    pop_ready = 1'b0;
    drive_push(1'b1, 32'h100);
    cyc();
    drive_push(1'b1, 32'h108);
    cyc();
    chk("stream_pre_count", 32'(count), 32'd2);
    pop_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_push(1'b1, 32'h110 + 32'(i * 8));
      chk($sformatf("stream_pc_%0d", i), pop_pc, 32'h100 + 32'(i * 8));
      chk($sformatf("stream_first_%0d", i), pop_first, 32'hA000_0100 + 32'(i * 8));
      cyc();
      chk($sformatf("stream_count_%0d", i), 32'(count), 32'd2);
    end
    // Head should now be pc 0x150
    pop_ready = 1'b0;
    drive_push(1'b1, 32'h200);
    cyc();
    chk("stream_post_count", 32'(count), 32'd3);
    chk("stream_post_head", pop_pc, 32'h150);

    // Flush with a same-cycle push
    drive_push(1'b1, 32'h300);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive_push(1'b0, 32'h0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_drops", 32'(flush_drops), 32'd3);
    chk("flush_pop_valid", 32'(pop_valid), 32'd0);
    drive_push(1'b1, 32'h500);
    cyc();
    drive_push(1'b0, 32'h0);
    chk("after_flush_count", 32'(count), 32'd1);
    chk("after_flush_head", pop_pc, 32'h500);

    // Saturation of the drop counter
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("sat_start", 32'(flush_drops), 32'd4);
    for (int i = 0; i < 85; i++) begin
      for (int k = 0; k < 3; k++) begin
        drive_push(1'b1, 32'h1000 + 32'(k * 8));
        cyc();
      end
      drive_push(1'b0, 32'h0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      if (i == 0)  chk("sat_first", 32'(flush_drops), 32'd7);
      if (i == 82) chk("sat_253", 32'(flush_drops), 32'd253);
      if (i == 83) chk("sat_clip", 32'(flush_drops), 32'd255);
    end
    chk("sat_hold", 32'(flush_drops), 32'd255);

    // Asynchronous reset between edges
    for (int k = 0; k < 3; k++) begin
      drive_push(1'b1, 32'h2000 + 32'(k * 8));
      cyc();
    end
    drive_push(1'b0, 32'h0);
    chk("areset_pre_count", 32'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("areset_count", 32'(count), 32'd0);
    chk("areset_pop_valid", 32'(pop_valid), 32'd0);
    chk("areset_drops", 32'(flush_drops), 32'd0);
    chk("areset_pop_pc", pop_pc, 32'h0);
    #2;
    reset = 1'b1;

    // First push accepted on the first edge after reset release
    drive_push(1'b1, 32'h3000);
    cyc();
    drive_push(1'b0, 32'h0);
    chk("post_reset_count", 32'(count), 32'd1);
    chk("post_reset_head", pop_pc, 32'h3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/inst_pair_queue.md
INST_PAIR_QUEUE -- requirements
Module: inst_pair_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of instruction-pair entries (power of two, 2..16).
REQ-002 SHALL have parameter NOP_EVEN, default 32'h40200000, even-pipe nop word presented when empty.
REQ-003 SHALL have parameter LNOP_ODD, default 32'h00200000, odd-pipe lnop word presented when empty.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port push_valid  input  1  fetch presents a pair.
REQ-007 SHALL have port push_ready  output  1  queue can accept a pair this cycle.
REQ-008 SHALL have port push_pc  input  [0:31]  PC of first_inst of the pair.
REQ-009 SHALL have port push_first, push_second  input  [0:31] each  instruction words, program order.
REQ-010 SHALL have port pop_valid  output  1  head entry available to decode.
REQ-011 SHALL have port pop_ready  input  1  decode consumes the head (low while decode stalls).
REQ-012 SHALL have port pop_pc, pop_first, pop_second  output  [0:31] each  head entry fields.
REQ-013 SHALL have port flush  input  1  branch-taken flush from the pipes.
REQ-014 SHALL have port count  output  [0:4]  current occupancy.
REQ-015 SHALL have port flush_drops  output  [0:7]  saturating count of entries discarded by flushes.

Function
REQ-016 Push fire = push_valid & push_ready; pop fire = pop_valid & pop_ready.
REQ-017 push_ready SHALL equal (count != DEPTH); it SHALL NOT depend on pop_ready.
REQ-018 pop_valid SHALL equal (count != 0).
REQ-019 Push fire SHALL write {push_pc, push_first, push_second} at wr_ptr and advance wr_ptr by 1 modulo DEPTH.
REQ-020 Pop fire SHALL advance rd_ptr by 1 modulo DEPTH; pop_* SHALL be a combinational read of the entry at rd_ptr.
REQ-021 No bypass: a pair pushed into an empty queue SHALL appear on pop_* one cycle after its push fire.
REQ-022 Simultaneous push fire and pop fire SHALL leave count unchanged and move both pointers.
REQ-023 count SHALL increment on push-only, decrement on pop-only, never exceed DEPTH or drop below 0.
REQ-024 When count == 0, pop_first SHALL be NOP_EVEN, pop_second SHALL be LNOP_ODD and pop_pc SHALL be 0.
REQ-025 flush high SHALL take priority over push/pop: next cycle count = 0, wr_ptr = rd_ptr = 0, and any same-cycle push is discarded.
REQ-026 On flush, flush_drops SHALL add the pre-flush count, saturating at 255.
REQ-027 pop_ready asserted with pop_valid low SHALL have no effect.
REQ-028 push_valid asserted with push_ready low SHALL have no effect; the producer holds its data.
REQ-029 Entry storage contents need not be reset; only pointers, count and flush_drops are reset.

Reset
REQ-030 While reset is low: count = 0, wr_ptr = rd_ptr = 0, flush_drops = 0, push_ready = 1, pop_valid = 0, pop_* = nop values per REQ-024.
REQ-031 Reset asserted mid-operation SHALL discard all entries immediately, asynchronously to clock.
REQ-032 First push fire SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-033 Fill: 4 pushes of pc 0x0,0x8,0x10,0x18, pop_ready=0 -> count=4, push_ready=0, pop_pc=0x0; 5th push ignored.
REQ-034 Drain: from full, pop_ready=1 for 4 cycles -> pop_pc 0x0,0x8,0x10,0x18 in order, then pop_valid=0 and pop_first=0x40200000.
REQ-035 Streaming: count=2, push and pop every cycle for 10 cycles -> count stays 2, output order matches input, pointers wrap without loss.
REQ-036 Flush: count=3 with push_valid=1 in the flush cycle -> next cycle count=0, flush_drops=3, pushed pair absent.
REQ-037 Saturation: 86 flushes of 3 entries each -> flush_drops=255, no wrap.
REQ-038 Async reset: count=3, reset low between clock edges -> count=0 and pop_valid=0 before the next edge.
